// File: rtl/hls_deadlock_reporter_if.sv
// Report record channel between the deadlock reporter and the sim/debug sink.
// HLS_DEADLOCK_REPORT_REARM_EN widens the record by the 8-bit report counter field.
interface hls_deadlock_reporter_if #(
  parameter int NUM_MON = 4,
  parameter int TS_W    = 32
);
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
  localparam int DATA_W = TS_W + NUM_MON + 6 + 8;
`else
  localparam int DATA_W = TS_W + NUM_MON + 6;
`endif

  logic              report_valid;
  logic              report_ready;
  logic [DATA_W-1:0] report_data;

  modport master (output report_valid, output report_data, input report_ready);
  modport slave  (input report_valid, input report_data, output report_ready);
endinterface

// File: rtl/hls_deadlock_reporter.sv
// Qualifies monitor block flags over a persistence window and emits one snapshot record per deadlock.
// Optional macro HLS_DEADLOCK_REPORT_REARM_EN: re-arm on block release plus a saturating report counter.
module hls_deadlock_reporter #(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 1024,
  parameter int CNT_W   = 16,
  parameter int TS_W    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MON-1:0]     mon_block,
  input  logic [1:0]             axis_block_sigs,
  input  logic [3:0]             inst_idle_sigs,
  input  logic                   clear,
  hls_deadlock_reporter_if.master rpt,
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
  output logic [7:0]             rpt_cnt,
`endif
  output logic                   deadlock
);
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
  localparam int REC_W = TS_W + NUM_MON + 6 + 8;
`else
  localparam int REC_W = TS_W + NUM_MON + 6;
`endif
  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1_C = CNT_W'(THRESH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, REPORT, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [TS_W-1:0]    ts_q;
  logic               valid_q, valid_d;
  logic [REC_W-1:0]   data_q, data_d;
  logic               dl_q, dl_d;
  logic               any_blk;
  logic               handshake;
  logic               qualify;
  logic [REC_W-1:0]   record;

  assign any_blk   = |mon_block;
  assign handshake = valid_q & rpt.report_ready;
  // pcnt only reaches THRESH-1 in IDLE (THRESH=1) or ARMED, so one compare covers both entry paths
  assign qualify   = any_blk && (pcnt_q == THRESH_M1_C);

`ifdef HLS_DEADLOCK_REPORT_REARM_EN
  logic [7:0] rpt_cnt_q;
  assign record  = {ts_q, mon_block, inst_idle_sigs, axis_block_sigs, rpt_cnt_q};
  assign rpt_cnt = rpt_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_cnt_q <= '0;
    end else if (handshake && (rpt_cnt_q != 8'hFF)) begin
      rpt_cnt_q <= rpt_cnt_q + 8'd1;
    end
  end
`else
  assign record = {ts_q, mon_block, inst_idle_sigs, axis_block_sigs};
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    dl_d    = dl_q;

    if ((state_q == LOCKED) || !any_blk) begin
      pcnt_d = '0;
    end else if (pcnt_q == THRESH_C) begin
      pcnt_d = pcnt_q;
    end else begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE, ARMED: begin
        if (qualify) begin
          state_d = REPORT;
          valid_d = 1'b1;
          data_d  = record;
        end else if (any_blk) begin
          state_d = ARMED;
        end else begin
          state_d = IDLE;
        end
        if (clear) dl_d = 1'b0;
      end
      // clear is deliberately ignored here: a presented record must complete its handshake
      REPORT: begin
        if (handshake) begin
          state_d = LOCKED;
          valid_d = 1'b0;
          dl_d    = 1'b1;
        end
      end
      LOCKED: begin
        if (clear) begin
          state_d = IDLE;
          dl_d    = 1'b0;
        end
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
        else if (!any_blk) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      ts_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ts_q    <= ts_q + TS_W'(1);
      valid_q <= valid_d;
      data_q  <= data_d;
      dl_q    <= dl_d;
    end
  end

  assign rpt.report_valid = valid_q;
  assign rpt.report_data  = data_q;
  assign deadlock         = dl_q;
endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Scoreboard bench for hls_deadlock_reporter with THRESH=4; records are checked by a handshake monitor.
// Build with HLS_DEADLOCK_REPORT_REARM_EN defined to exercise the re-arm variant.
module tb_hls_deadlock_reporter;
  localparam int NUM_MON = 4;
  localparam int TS_W    = 32;
  localparam int THRESH  = 4;
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
  localparam int REC_W = TS_W + NUM_MON + 6 + 8;
`else
  localparam int REC_W = TS_W + NUM_MON + 6;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] mon_block = '0;
  logic [1:0] axis_block_sigs = '0;
  logic [3:0] inst_idle_sigs = '0;
  logic       clear = 1'b0;
  logic       deadlock;
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
  logic [7:0] rpt_cnt;
  logic [7:0] exp_cnt = '0;
`endif

  hls_deadlock_reporter_if #(.NUM_MON(NUM_MON), .TS_W(TS_W)) rpt_if ();

  hls_deadlock_reporter #(
    .NUM_MON(NUM_MON), .THRESH(THRESH), .CNT_W(16), .TS_W(TS_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .mon_block       (mon_block),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .clear           (clear),
    .rpt             (rpt_if),
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
    .rpt_cnt         (rpt_cnt),
`endif
    .deadlock        (deadlock)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [31:0] ts_model;

  always @(posedge clock) begin
    if (reset) ts_model <= '0;
    else       ts_model <= ts_model + 32'd1;
  end

  function automatic logic [REC_W-1:0] mk(input logic [31:0] ts, input logic [3:0] mon,
                                          input logic [3:0] idl, input logic [1:0] ax);
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
    return {ts, mon, idl, ax, exp_cnt};
`else
    return {ts, mon, idl, ax};
`endif
  endfunction

  task automatic bump_cnt();
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
  endtask

  task automatic zero_cnt();
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
    exp_cnt = '0;
`endif
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted record must match the next expected record in order
  always @(negedge clock) begin
    if (!reset && rpt_if.report_valid && rpt_if.report_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record: got %h expected none", rpt_if.report_data);
      end else begin
        chk("record", 64'(rpt_if.report_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REC_W-1:0] rec;
    logic             seen;

    rpt_if.report_ready = 1'b0;
    step(3);
    chk("rst_valid", 64'(rpt_if.report_valid), 64'd0);
    chk("rst_data", 64'(rpt_if.report_data), 64'd0);
    chk("rst_deadlock", 64'(deadlock), 64'd0);
`ifdef HLS_DEADLOCK_REPORT_REARM_EN
    chk("rst_rpt_cnt", 64'(rpt_cnt), 64'd0);
`endif
    reset = 1'b0;

    // A: 3-cycle block is below threshold
    mon_block = 4'b0010;
    step(3);
    chk("A_no_valid_blocking", 64'(rpt_if.report_valid), 64'd0);
    mon_block = 4'b0000;
    step(3);
    chk("A_no_valid_after", 64'(rpt_if.report_valid), 64'd0);

    // B: capture at ts=0x10
    while (ts_model != 32'd13) step(1);
    axis_block_sigs = 2'b01;
    inst_idle_sigs  = 4'b1100;
    mon_block       = 4'b0010;
    rec = mk(32'h10, 4'b0010, 4'b1100, 2'b01);
    exp_q.push_back(rec);
    step(3);
    chk("B_not_yet", 64'(rpt_if.report_valid), 64'd0);
    step(1);
    chk("B_valid_latency", 64'(rpt_if.report_valid), 64'd1);
    chk("B_data", 64'(rpt_if.report_data), 64'(rec));

    // C: back-pressure with changing inputs; record must hold
    for (int i = 0; i < 5; i++) begin
      mon_block       = (i % 2 == 1) ? 4'b1000 : 4'b0010;
      axis_block_sigs = 2'(i);
      inst_idle_sigs  = 4'(i + 3);
      step(1);
      chk("C_valid_hold", 64'(rpt_if.report_valid), 64'd1);
      chk("C_data_hold", 64'(rpt_if.report_data), 64'(rec));
    end
    mon_block = 4'b0001;
    rpt_if.report_ready = 1'b1;
    step(1);
    rpt_if.report_ready = 1'b0;
    bump_cnt();
    chk("C_deadlock_set", 64'(deadlock), 64'd1);
    chk("C_valid_drop", 64'(rpt_if.report_valid), 64'd0);
    chk("C_data_retained", 64'(rpt_if.report_data), 64'(rec));

    // D: LOCKED ignores a long block; clear releases it
    rpt_if.report_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      step(1);
      if (rpt_if.report_valid) seen = 1'b1;
    end
    chk("D_no_report_locked", 64'(seen), 64'd0);
    chk("D_deadlock_sticky", 64'(deadlock), 64'd1);
    mon_block = 4'b0000;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("D_clear_deadlock", 64'(deadlock), 64'd0);
    mon_block       = 4'b0100;
    inst_idle_sigs  = 4'b0011;
    axis_block_sigs = 2'b10;
    rec = mk(ts_model + 32'd3, 4'b0100, 4'b0011, 2'b10);
    exp_q.push_back(rec);
    step(3);
    chk("D_not_yet", 64'(rpt_if.report_valid), 64'd0);
    step(1);
    chk("D_valid", 64'(rpt_if.report_valid), 64'd1);
    step(1);
    bump_cnt();
    chk("D_deadlock_set", 64'(deadlock), 64'd1);
    chk("D_valid_drop", 64'(rpt_if.report_valid), 64'd0);
    rpt_if.report_ready = 1'b0;
    mon_block = 4'b0000;
    step(1);

    // E: clear alone in REPORT ignored; clear with handshake loses to handshake
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    mon_block       = 4'b1000;
    inst_idle_sigs  = 4'b0101;
    axis_block_sigs = 2'b11;
    rec = mk(ts_model + 32'd3, 4'b1000, 4'b0101, 2'b11);
    exp_q.push_back(rec);
    step(4);
    chk("E_valid", 64'(rpt_if.report_valid), 64'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("E_clear_ignored_valid", 64'(rpt_if.report_valid), 64'd1);
    chk("E_clear_ignored_data", 64'(rpt_if.report_data), 64'(rec));
    rpt_if.report_ready = 1'b1;
    clear = 1'b1;
    step(1);
    rpt_if.report_ready = 1'b0;
    clear = 1'b0;
    bump_cnt();
    chk("E_hs_wins_deadlock", 64'(deadlock), 64'd1);
    chk("E_hs_wins_valid", 64'(rpt_if.report_valid), 64'd0);
    mon_block = 4'b0000;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;

    // F: reset in REPORT drops the record
    mon_block = 4'b0010;
    step(4);
    chk("F_valid_before_reset", 64'(rpt_if.report_valid), 64'd1);
    mon_block = 4'b0000;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    zero_cnt();
    chk("F_reset_valid", 64'(rpt_if.report_valid), 64'd0);
    chk("F_reset_data", 64'(rpt_if.report_data), 64'd0);
    chk("F_reset_deadlock", 64'(deadlock), 64'd0);
    mon_block = 4'b0001;
    rec = mk(32'd3, 4'b0001, 4'b0101, 2'b11);
    exp_q.push_back(rec);
    step(3);
    chk("F_idle_not_yet", 64'(rpt_if.report_valid), 64'd0);
    step(1);
    chk("F_idle_valid", 64'(rpt_if.report_valid), 64'd1);
    rpt_if.report_ready = 1'b1;
    step(1);
    rpt_if.report_ready = 1'b0;
    bump_cnt();
    chk("F_deadlock_set", 64'(deadlock), 64'd1);
    mon_block = 4'b0000;
    step(1);

`ifdef HLS_DEADLOCK_REPORT_REARM_EN
    // G: two deadlocks separated by one idle cycle, ready tied high
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    zero_cnt();
    rpt_if.report_ready = 1'b1;
    mon_block = 4'b0001;
    rec = mk(ts_model + 32'd3, 4'b0001, 4'b0101, 2'b11);
    exp_q.push_back(rec);
    step(5);
    bump_cnt();
    mon_block = 4'b0000;
    step(1);
    mon_block = 4'b0001;
    rec = mk(ts_model + 32'd3, 4'b0001, 4'b0101, 2'b11);
    exp_q.push_back(rec);
    step(5);
    bump_cnt();
    mon_block = 4'b0000;
    rpt_if.report_ready = 1'b0;
    chk("G_rpt_cnt", 64'(rpt_cnt), 64'd2);
    chk("G_deadlock", 64'(deadlock), 64'd1);
`endif

    step(3);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
